// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the immediate-extension helper.
// Used by the decode-to-execute constant/flag slice.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 15;
  localparam int EXT_W  = DATA_W - IMM_W;

  localparam logic CS_ZERO = 1'b0;
  localparam logic CS_SIGN = 1'b1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IMM_W-1:0]  imm_t;

  function automatic data_t ext_imm(
    input imm_t imm,
    input logic cs
  );
    data_t r;
    r = {{EXT_W{1'b0}}, imm};
    unique case (1'b1)
      (cs == CS_SIGN): r = {{EXT_W{imm[IMM_W-1]}}, imm};
      (cs == CS_ZERO): r = {{EXT_W{1'b0}}, imm};
      default:         r = {{EXT_W{1'b0}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_const_flag_stage_if.sv
// Bundle of immediate, constant and control-flag signals
// between decode and the constant/flag slice.
interface imm_const_flag_stage_if;
  import pipe_pkg::*;

  imm_t  imm;
  logic  cs;
  data_t const_out;
  data_t const_q;
  logic  ld1;
  logic  d1;
  logic  q1;
  logic  ld2;
  logic  [1:0] d2;
  logic  [1:0] q2;

  modport master (
    output imm, cs, ld1, d1, ld2, d2,
    input  const_out, const_q, q1, q2
  );

  modport slave (
    input  imm, cs, ld1, d1, ld2, d2,
    output const_out, const_q, q1, q2
  );

endinterface

// File: rtl/pipe_dff.sv
// Loadable pipeline register with asynchronous
// active-low clear to zero.
module pipe_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign q_d = load ? d : q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/imm_const_flag_stage.sv
// Immediate extension plus 1/2-bit control-field registers.
// IMM_CONST_REG_EN registers the constant; else it passes through.
module imm_const_flag_stage
  import pipe_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  imm_const_flag_stage_if.slave bus
);

  data_t      const_d;
  data_t      const_r;
  logic       q1_w;
  logic [1:0] q2_w;

  assign const_d = ext_imm(bus.imm, bus.cs);
  assign bus.const_out = const_d;

  pipe_dff #(.W(1)) u_r1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bus.ld1),
    .d     (bus.d1),
    .q     (q1_w)
  );

  pipe_dff #(.W(2)) u_r2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bus.ld2),
    .d     (bus.d2),
    .q     (q2_w)
  );

`ifdef IMM_CONST_REG_EN
  pipe_dff #(.W(DATA_W)) u_rc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .d     (const_d),
    .q     (const_r)
  );
`else
  assign const_r = const_d;
`endif

  assign bus.const_q = const_r;
  assign bus.q1      = q1_w;
  assign bus.q2      = q2_w;

endmodule

// File: tb/tb_imm_const_flag_stage.sv
// Scoreboard bench for imm_const_flag_stage.
// Stimulus queues expectations; a monitor compares on each sample.
module tb_imm_const_flag_stage;

  logic clk;
  logic rst_n;

  imm_const_flag_stage_if bus();

  imm_const_flag_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_COUT = 0;
  localparam int S_CQ   = 1;
  localparam int S_Q1   = 2;
  localparam int S_Q2   = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event smp;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int sel,
                     input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic sample();
    -> smp;
    #1;
  endtask

  initial begin : monitor
    exp_t        x;
    logic [31:0] act;
    forever begin
      @(smp);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.sel)
          S_COUT:  act = bus.const_out;
          S_CQ:    act = bus.const_q;
          S_Q1:    act = {31'b0, bus.q1};
          default: act = {30'b0, bus.q2};
        endcase
        n_chk++;
        if (act === x.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h",
                      x.tag, act, x.exp);
      end
    end
  end

  task automatic comb(input logic [14:0] imm, input logic cs,
                      input logic [31:0] e, input string tag);
    bus.imm = imm;
    bus.cs  = cs;
    #1;
    chk(tag, S_COUT, e);
`ifndef IMM_CONST_REG_EN
    chk({tag, "_cq"}, S_CQ, e);
`endif
    sample();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    rst_n   = 1'b0;
    bus.imm = '0;
    bus.cs  = 1'b0;
    bus.ld1 = 1'b0;
    bus.d1  = 1'b0;
    bus.ld2 = 1'b0;
    bus.d2  = 2'b00;
    #1;
    chk("rst_q1", S_Q1, 32'h0);
    chk("rst_q2", S_Q2, 32'h0);
`ifdef IMM_CONST_REG_EN
    chk("rst_cq", S_CQ, 32'h0);
`endif
    sample();

    comb(15'h4000, 1'b1, 32'hFFFFC000, "sx4000");
    comb(15'h4000, 1'b0, 32'h00004000, "zx4000");
    comb(15'h3FFF, 1'b1, 32'h00003FFF, "sx3fff");
    comb(15'h7FFF, 1'b1, 32'hFFFFFFFF, "sx7fff");
    comb(15'h7FFF, 1'b0, 32'h00007FFF, "zx7fff");
    comb(15'h0000, 1'b1, 32'h00000000, "sx0");
    comb(15'h5A5A, 1'b1, 32'hFFFFDA5A, "sx5a5a");

    // first edge after release must capture the load
    @(negedge clk);
    rst_n   = 1'b1;
    bus.ld2 = 1'b1;
    bus.d2  = 2'b10;
    @(negedge clk);
    chk("ld2_cap", S_Q2, 32'h2);
    chk("q1_idle", S_Q1, 32'h0);
    sample();

    bus.ld2 = 1'b0;
    bus.d2  = 2'b01;
    @(negedge clk);
    chk("ld2_hold", S_Q2, 32'h2);
    sample();

    bus.ld1 = 1'b1;
    bus.d1  = 1'b1;
    bus.ld2 = 1'b1;
    bus.d2  = 2'b11;
    @(negedge clk);
    chk("sim_q1", S_Q1, 32'h1);
    chk("sim_q2", S_Q2, 32'h3);
    sample();

    rst_n = 1'b0;
    #1;
    chk("pulse_q1", S_Q1, 32'h0);
    chk("pulse_q2", S_Q2, 32'h0);
    sample();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_q1", S_Q1, 32'h1);
    chk("rel_q2", S_Q2, 32'h3);
    sample();

    bus.ld1 = 1'b0;
    bus.ld2 = 1'b0;
    rst_n   = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("nold_q1", S_Q1, 32'h0);
    chk("nold_q2", S_Q2, 32'h0);
    sample();

    bus.imm = 15'h0005;
    bus.cs  = 1'b0;
`ifdef IMM_CONST_REG_EN
    @(negedge clk);
    chk("creg", S_CQ, 32'h5);
    sample();
    bus.imm = 15'h4001;
    bus.cs  = 1'b1;
    #1;
    chk("creg_old", S_CQ, 32'h5);
    sample();
    @(negedge clk);
    chk("creg_sx", S_CQ, 32'hFFFFC001);
    sample();
`else
    #1;
    chk("cpass", S_CQ, 32'h5);
    sample();
`endif

    #1;
    if (sb.size() > 0) begin
      $display("FAIL leftover: got %0d expected 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
